// File: rtl/fifo_protocol_checker.sv
// Passive cycle-by-cycle checker for a synchronous FIFO: shadow occupancy model, flag/data compare, counters.
// Define FIFO_CHK_DATA_CHECK_EN to add the shadow data store and read-data check (err_flags[7]).
module fifo_protocol_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         chk_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic [DATA_WIDTH-1:0]        data_out,
   input  logic                         wr_ack,
   input  logic                         overflow,
   input  logic                         underflow,
   input  logic                         full,
   input  logic                         empty,
   input  logic                         almostfull,
   input  logic                         almostempty,
   output logic [$clog2(DEPTH+1)-1:0]   mon_count,
   output logic [7:0]                   err_flags,
   output logic                         err_any,
   output logic [2:0]                   first_err,
   output logic [CNT_WIDTH-1:0]         correct_count,
   output logic [CNT_WIDTH-1:0]         error_count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(DEPTH-1);
   localparam logic [CW-1:0] AE_C   = CW'(1);

   logic [CW-1:0]        count_q, count_d;
   logic                 pend_q, pend_d;
   logic                 exp_wr_ack_q, exp_ovf_q, exp_udf_q;
   logic [7:0]           err_flags_q, err_flags_d;
   logic [2:0]           first_err_q, first_err_d;
   logic [CNT_WIDTH-1:0] correct_q, correct_d;
   logic [CNT_WIDTH-1:0] error_q, error_d;
   logic                 full_m, empty_m, write_ok, read_ok, check, data_mism;
   logic [7:0]           mism;
   logic [2:0]           mism_idx;

`ifdef FIFO_CHK_DATA_CHECK_EN
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] exp_data_q;
   logic                  exp_dv_q;

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         exp_data_q <= '0;
         exp_dv_q   <= 1'b0;
      end else begin
         exp_dv_q <= read_ok;
         if (write_ok)
            wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
         if (read_ok) begin
            exp_data_q <= mem_q[rd_ptr_q];
            rd_ptr_q   <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (write_ok)
         mem_q[wr_ptr_q] <= data_in;
   end

   assign data_mism = exp_dv_q & (data_out != exp_data_q);
`else
   logic unused_data;
   assign unused_data = ^{data_in, data_out};
   assign data_mism   = 1'b0;
`endif

   always_comb begin
      full_m   = (count_q == FULL_C);
      empty_m  = (count_q == '0);
      write_ok = wr_en & ~full_m;
      read_ok  = rd_en & ~empty_m;
      count_d  = count_q + CW'(write_ok) - CW'(read_ok);
      check    = chk_en & pend_q;

      mism[0] = full        ^ full_m;
      mism[1] = empty       ^ empty_m;
      mism[2] = almostfull  ^ (count_q == AF_C);
      mism[3] = almostempty ^ (count_q == AE_C);
      mism[4] = wr_ack      ^ exp_wr_ack_q;
      mism[5] = overflow    ^ exp_ovf_q;
      mism[6] = underflow   ^ exp_udf_q;
      mism[7] = data_mism;

      mism_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (mism[i]) mism_idx = 3'(i);

      err_flags_d = err_flags_q;
      first_err_d = first_err_q;
      correct_d   = correct_q;
      error_d     = error_q;
      pend_d      = 1'b1;

      // clear wins over counting; the shadow model keeps tracking regardless.
      if (clear) begin
         err_flags_d = '0;
         first_err_d = '0;
         correct_d   = '0;
         error_d     = '0;
         pend_d      = 1'b0;
      end else if (check) begin
         if (mism == 8'h00) begin
            if (correct_q != '1) correct_d = correct_q + 1'b1;
         end else begin
            if (error_q != '1) error_d = error_q + 1'b1;
            err_flags_d = err_flags_q | mism;
            if (err_flags_q == 8'h00) first_err_d = mism_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q      <= '0;
         pend_q       <= 1'b0;
         exp_wr_ack_q <= 1'b0;
         exp_ovf_q    <= 1'b0;
         exp_udf_q    <= 1'b0;
         err_flags_q  <= '0;
         first_err_q  <= '0;
         correct_q    <= '0;
         error_q      <= '0;
      end else begin
         count_q      <= count_d;
         pend_q       <= pend_d;
         exp_wr_ack_q <= write_ok;
         exp_ovf_q    <= wr_en & full_m;
         exp_udf_q    <= rd_en & empty_m;
         err_flags_q  <= err_flags_d;
         first_err_q  <= first_err_d;
         correct_q    <= correct_d;
         error_q      <= error_d;
      end
   end

   assign mon_count     = count_q;
   assign err_flags     = err_flags_q;
   assign err_any       = |err_flags_q;
   assign first_err     = first_err_q;
   assign correct_count = correct_q;
   assign error_count   = error_q;
endmodule
